div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle controller for the special hi/lo divide resource. It accepts one DIV/DIVU issue, runs an iterative restoring divide (one quotient bit per cycle), and applies the sign fixup. It then presents hi (remainder) and lo (quotient) with a one-cycle done pulse for the writeback path (has_div_w/div_hi_w/div_lo_w). While a divide is in flight it raises a stall so that MFHI/MFLO in decode cannot read stale hi/lo.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start_e  in  1  divide issue from execute; sampled only in IDLE.
- is_signed_e  in  1  1 = DIV (signed), 0 = DIVU.
- dividend_e  in  WIDTH  rs value.
- divisor_e  in  WIDTH  rt value.
- mf_op_in_d  in  1  decode holds MFHI/MFLO.
- busy  out  1  divide in flight (any state except IDLE).
- stall_d  out  1  stall request to the hazard unit.
- done  out  1  one-cycle pulse; hi/lo valid.
- div_hi  out  WIDTH  remainder.
- div_lo  out  WIDTH  quotient.
- div_by_zero  out  1  divisor was zero; valid with done.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high, on `reset`. Reset forces state IDLE, counter 0, busy=0, done=0, div_hi=0, div_lo=0, div_by_zero=0.
- Reset mid-operation: the in-flight divide is aborted, no done pulse is produced, and the outputs return to reset values on the next edge.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE transition: when start_e=1, capture operands into internal registers:
  - |dividend| and |divisor| in signed mode, raw values otherwise;
  - the sign flags;
  - zero-divisor flag.
  - Set counter=WIDTH-1, clear partial remainder, go to CALC.
- CALC, one restoring step per cycle:
  - rem' = {rem[WIDTH-2:0], q[WIDTH-1]}; q shifts left.
  - If rem' >= divisor, then rem = rem' - divisor and q[0]=1; else rem = rem' and q[0]=0.
  - Comparison and subtraction are done at WIDTH+1 bits, so no overflow occurs.
  - When counter==0, go to FIXUP; otherwise decrement the counter.
- FIXUP:
  - Signed: negate q if the operand signs differ; negate rem if the dividend was negative.
  - Divisor zero (either mode): lo=all ones, hi=original dividend, div_by_zero=1. This overrides the sign fixup.
  - Load div_hi/div_lo, then go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. div_hi/div_lo hold until the next FIXUP or reset.
- Latency: start sampled at edge t gives done=1 during the cycle after edge t+WIDTH+1. That is 34 cycles for WIDTH=32, fixed for all operands.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- start_e while busy: ignored. No state change, no error. The hazard unit is responsible for not issuing it.
- start_e during DONE: ignored. It is accepted only once back in IDLE.
- Stall: stall_d = mf_op_in_d & busy, combinational. It covers DONE and deasserts in the IDLE cycle that follows done.
- busy is registered; it is 1 from the cycle after start is accepted through the DONE cycle.

Decomposition:
- Package div_seq_pkg:
  - state enum (IDLE=0, CALC=1, FIXUP=2, DONE=3);
  - DIV_LATENCY = WIDTH+2;
  - the divide-by-zero constants.
- Natural sub-module div_step: combinational single restoring iteration. Inputs are rem, q and divisor; outputs are next rem and next q.
- The FSM, counter and fixup stay in div_sequencer.

Test Plan:
- DIVU 100/7 → done exactly 34 cycles after start, div_lo=14, div_hi=2, div_by_zero=0.
- DIV -7/2 (0xFFFFFFF9 / 2) → div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF.
- DIVU 5/0 and DIV -5/0 → div_lo=0xFFFFFFFF, div_by_zero=1. div_hi=5 and 0xFFFFFFFB respectively; latency is still 34.
- DIV 0x80000000/0xFFFFFFFF → div_lo=0x80000000, div_hi=0. A second start_e pulsed at cycle 10 is ignored: exactly one done, results unchanged.
- mf_op_in_d=1 held from cycle 3 → stall_d=1 through the done cycle and 0 the cycle after. mf_op_in_d=1 while IDLE → stall_d=0.
- Reset asserted at cycle 20 of a divide → next cycle busy=0, outputs 0, no done pulse. A new DIVU 9/3 then yields lo=3, hi=0 after 34 cycles.

Source files
------------

// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared types and constants for the hi/lo divide sequencer
//
// Contents:
//   div_state_t   - sequencer state encoding (IDLE, CALC, FIXUP, DONE)
//   DIV_WIDTH     - default operand/result width
//   DIV_LATENCY   - cycles from the accepting start edge to the done cycle, inclusive
//   DIV0_*        - result pattern for a zero divisor

package div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    // A zero divisor fills every quotient bit with this value, returns the
    // original dividend as remainder, and raises div_by_zero.
    localparam logic DIV0_LO_FILL = 1'b1;
    localparam logic DIV0_FLAG    = 1'b1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-divide iteration
//
// Ports:
//   rem      in  WIDTH  partial remainder (always < divisor between steps)
//   q        in  WIDTH  dividend/quotient shift register
//   divisor  in  WIDTH  magnitude of the divisor
//   rem_next out WIDTH  partial remainder after this step
//   q_next   out WIDTH  shift register after this step, new quotient bit in bit 0

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    // Shift in the next dividend bit at WIDTH+1 bits so a remainder with its
    // MSB set (divisor above 2^(WIDTH-1)) is not lost.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;
    logic           ge;
    logic           unused_diff_msb;

    assign rem_shift = {rem, q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, divisor};
    assign ge        = (rem_shift >= {1'b0, divisor});

    // Since rem < divisor, rem_shift < 2*divisor, so diff fits in WIDTH bits
    // whenever it is selected.
    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        rem_next = rem_shift[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
        if (ge) begin
            rem_next = diff[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle DIV/DIVU controller for the hi/lo resource
//
// Ports:
//   clock        in   1      system clock, rising edge
//   reset        in   1      synchronous active-high reset
//   start_e      in   1      divide issue from execute, accepted only in IDLE
//   is_signed_e  in   1      1 = DIV (signed), 0 = DIVU
//   dividend_e   in   WIDTH  rs value
//   divisor_e    in   WIDTH  rt value
//   mf_op_in_d   in   1      decode holds MFHI/MFLO
//   busy         out  1      divide in flight (CALC, FIXUP or DONE)
//   stall_d      out  1      hazard-unit stall: mf_op_in_d & busy
//   done         out  1      one-cycle pulse, div_hi/div_lo/div_by_zero valid
//   div_hi       out  WIDTH  remainder
//   div_lo       out  WIDTH  quotient
//   div_by_zero  out  1      divisor was zero

module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_e,
    input  logic             is_signed_e,
    input  logic [WIDTH-1:0] dividend_e,
    input  logic [WIDTH-1:0] divisor_e,
    input  logic             mf_op_in_d,
    output logic             busy,
    output logic             stall_d,
    output logic             done,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    div_state_t       state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] dividend_raw;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_r),
        .q        (q_r),
        .divisor  (divisor_r),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_e) state_next = CALC;
            CALC:    if (count == '0) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The zero-divisor result takes precedence over any sign correction.
    always_comb begin
        fix_lo = neg_q ? -q_r : q_r;
        fix_hi = neg_r ? -rem_r : rem_r;
        if (zero_div) begin
            fix_lo = {WIDTH{DIV0_LO_FILL}};
            fix_hi = dividend_raw;
        end
    end

    assign stall_d = mf_op_in_d & busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            rem_r        <= '0;
            q_r          <= '0;
            divisor_r    <= '0;
            dividend_raw <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            zero_div     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_hi       <= '0;
            div_lo       <= '0;
            div_by_zero  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start_e) begin
                        q_r          <= (is_signed_e && dividend_e[WIDTH-1]) ? -dividend_e : dividend_e;
                        divisor_r    <= (is_signed_e && divisor_e[WIDTH-1])  ? -divisor_e  : divisor_e;
                        dividend_raw <= dividend_e;
                        neg_q        <= is_signed_e & (dividend_e[WIDTH-1] ^ divisor_e[WIDTH-1]);
                        neg_r        <= is_signed_e & dividend_e[WIDTH-1];
                        zero_div     <= (divisor_e == '0);
                        rem_r        <= '0;
                        count        <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    rem_r <= rem_next;
                    q_r   <= q_next;
                    if (count != '0) count <= count - 1'b1;
                end
                FIXUP: begin
                    div_hi      <= fix_hi;
                    div_lo      <= fix_lo;
                    div_by_zero <= zero_div ? DIV0_FLAG : 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard testbench for div_sequencer

module tb_div_sequencer;
    import div_seq_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start_e;
    logic         is_signed_e;
    logic [W-1:0] dividend_e;
    logic [W-1:0] divisor_e;
    logic         mf_op_in_d;
    logic         busy;
    logic         stall_d;
    logic         done;
    logic [W-1:0] div_hi;
    logic [W-1:0] div_lo;
    logic         div_by_zero;

    div_sequencer #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start_e     (start_e),
        .is_signed_e (is_signed_e),
        .dividend_e  (dividend_e),
        .divisor_e   (divisor_e),
        .mf_op_in_d  (mf_op_in_d),
        .busy        (busy),
        .stall_d     (stall_d),
        .done        (done),
        .div_hi      (div_hi),
        .div_lo      (div_lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   chk = 0;
    int   err = 0;
    int   cyc = 0;
    int   done_count = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk++;
        if (act !== req) begin
            err++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        e.start_cyc = 0;
        e.dbz       = (b == 32'd0);
        if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
        end else if (sgn) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            qq   = sa / sb;
            rr   = sa % sb;
            e.lo = qq[31:0];
            e.hi = rr[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("div_lo", div_lo, e.lo);
                check("div_hi", div_hi, e.hi);
                check("div_by_zero", div_by_zero, e.dbz);
                check("latency", cyc - e.start_cyc + 1, DIV_LATENCY);
            end
        end
    end

    // Returns at the negedge right after the accepting edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        start_e     = 1'b1;
        is_signed_e = sgn;
        dividend_e  = a;
        divisor_e   = b;
        e           = model(sgn, a, b);
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clock);
        start_e = 1'b0;
    endtask

    task automatic wait_done();
        int n0;
        bit got;
        n0  = done_count;
        got = 1'b0;
        for (int i = 0; i < DIV_LATENCY + 4; i++) begin
            @(negedge clock);
            #1;
            if (done_count != n0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic run_directed(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        issue(sgn, a, b);
        wait_done();
        @(negedge clock);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int n0;
        logic [31:0] ra;
        logic [31:0] rb;
        reset       = 1'b1;
        start_e     = 1'b0;
        is_signed_e = 1'b0;
        dividend_e  = '0;
        divisor_e   = '0;
        mf_op_in_d  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", div_hi, 0);
        check("rst_lo", div_lo, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_stall", stall_d, 0);

        run_directed(1'b0, 32'd100, 32'd7);
        run_directed(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_directed(1'b0, 32'd5, 32'd0);
        run_directed(1'b1, 32'hFFFF_FFFB, 32'd0);

        // Overflow case plus a start pulse that must be ignored while busy.
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (10) @(negedge clock);
        start_e     = 1'b1;
        is_signed_e = 1'b0;
        dividend_e  = 32'd1234;
        divisor_e   = 32'd5;
        @(negedge clock);
        start_e = 1'b0;
        wait_done();
        n0 = done_count;
        repeat (DIV_LATENCY + 6) @(negedge clock);
        check("ignored_start_done_count", done_count, n0);
        check("ignored_start_lo_held", div_lo, 32'h8000_0000);
        check("ignored_start_hi_held", div_hi, 32'h0);

        // Stall window: mf_op_in_d raised from cycle 3, held into IDLE.
        issue(1'b0, 32'd77777, 32'd13);
        for (int k = 0; k < DIV_LATENCY + 2; k++) begin
            if (k >= 3) mf_op_in_d = 1'b1;
            #1;
            check($sformatf("stall_k%0d", k), stall_d, (k >= 3) && (k <= DIV_LATENCY - 1));
            check($sformatf("busy_k%0d", k), busy, k <= DIV_LATENCY - 1);
            @(negedge clock);
        end
        mf_op_in_d = 1'b0;

        // Randomized operands, biased toward zero/small/extreme divisors.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = $urandom;
                default: rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1;
            endcase
            issue(1'($urandom_range(0, 1)), ra, rb);
            wait_done();
        end

        // Reset in the middle of a divide: abort, no done.
        issue(1'b0, 32'd1000, 32'd7);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", div_hi, 0);
        check("abort_lo", div_lo, 0);
        check("abort_dbz", div_by_zero, 0);
        n0 = done_count;
        repeat (DIV_LATENCY + 6) @(negedge clock);
        check("abort_no_done", done_count, n0);

        run_directed(1'b0, 32'd9, 32'd3);

        repeat (4) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
